cdu_mode_sequencer: RTL and testbench

Sequences the CDU resolver-to-digital converter through its zero, coarse and fine conversion modes by driving the ADC1..ADC12 mode-select lines that the testbench currently toggles by hand. Qualifies every mode change against comparator error flags, sampled once per 800 Hz reference cycle. Declares lock when fine tracking is stable and a fault when coarse acquisition times out. Sits between the CDU control logic (start/abort, fine enable) and the converter's mode switches.

---
 rtl/cdu_mode_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_cdu_mode_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdu_mode_sequencer.sv
// Mode sequencer for the CDU resolver-to-digital converter: walks ZERO -> COARSE -> FINE,
// qualifies each step on reference ticks and inserts a break cycle between non-zero adc patterns.
module cdu_mode_sequencer #(
    parameter int unsigned ZERO_TICKS    = 8,
    parameter int unsigned SETTLE_TICKS  = 4,
    parameter int unsigned LOSS_TICKS    = 2,
    parameter int unsigned TIMEOUT_TICKS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        fine1_en,
    input  logic        ref_tick,
    input  logic        coarse_ok,
    input  logic        fine_ok,
    output logic [11:0] adc,
    output logic [2:0]  mode,
    output logic        locked,
    output logic        fault,
    output logic        mode_chg
);

    localparam int unsigned TMAX = (TIMEOUT_TICKS > ZERO_TICKS) ? TIMEOUT_TICKS : ZERO_TICKS;
    localparam int TW = $clog2(TMAX) + 1;
    localparam int SW = $clog2(SETTLE_TICKS) + 1;
    localparam int LW = $clog2(LOSS_TICKS) + 1;

    localparam logic [TW-1:0] ZERO_LAST    = TW'(ZERO_TICKS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_TICKS);
    localparam logic [LW-1:0] LOSS_LAST    = LW'(LOSS_TICKS - 1);

    // BRK_* states hold adc at zero for one cycle before the named pattern is applied
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ZERO       = 3'd1,
        S_COARSE     = 3'd2,
        S_FINE       = 3'd3,
        S_FAULT      = 3'd4,
        S_BRK_COARSE = 3'd5,
        S_BRK_FINE   = 3'd6
    } state_t;

    state_t          state_r, state_next_s;
    logic [TW-1:0]   tick_cnt_r, tick_cnt_next_s;
    logic [SW-1:0]   settle_cnt_r, settle_cnt_next_s, settle_inc_s;
    logic [LW-1:0]   loss_cnt_r, loss_cnt_next_s;
    logic            locked_r, locked_next_s;
    logic [11:0]     adc_r, adc_next_s;
    logic [2:0]      mode_r, mode_next_s;
    logic            fault_r, fault_next_s;
    logic            mode_chg_r, mode_chg_next_s;
    logic            entering_s;

    function automatic logic [11:0] adc_pattern(input state_t st);
        case (st)
            S_ZERO:   adc_pattern = 12'h002;
            S_COARSE: adc_pattern = 12'h011;
            S_FINE:   adc_pattern = 12'h028;
            default:  adc_pattern = 12'h000;
        endcase
    endfunction

    // Next-state and counter logic; abort overrides every other transition
    always_comb begin
        state_next_s      = state_r;
        tick_cnt_next_s   = tick_cnt_r;
        settle_cnt_next_s = settle_cnt_r;
        loss_cnt_next_s   = loss_cnt_r;
        locked_next_s     = locked_r;
        settle_inc_s      = (settle_cnt_r == SETTLE_MAX) ? SETTLE_MAX : settle_cnt_r + 1'b1;
        if (abort) begin
            state_next_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE, S_FAULT: begin
                    if (start) begin
                        state_next_s = S_ZERO;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                S_ZERO: begin
                    if (ref_tick && (tick_cnt_r >= ZERO_LAST)) begin
                        state_next_s = S_BRK_COARSE;
                    end else if (ref_tick) begin
                        tick_cnt_next_s = tick_cnt_r + 1'b1;
                    end else begin
                        tick_cnt_next_s = tick_cnt_r;
                    end
                end
                S_COARSE: begin
                    if (ref_tick) begin
                        settle_cnt_next_s = coarse_ok ? settle_inc_s : {SW{1'b0}};
                        // the FINE condition wins over a timeout on the same tick
                        if (coarse_ok && (settle_inc_s == SETTLE_MAX) && fine1_en) begin
                            state_next_s = S_BRK_FINE;
                        end else if (tick_cnt_r >= TIMEOUT_LAST) begin
                            state_next_s = S_FAULT;
                        end else begin
                            tick_cnt_next_s = tick_cnt_r + 1'b1;
                        end
                    end else begin
                        settle_cnt_next_s = settle_cnt_r;
                    end
                end
                S_FINE: begin
                    if (!fine1_en) begin
                        state_next_s = S_BRK_COARSE;
                    end else if (ref_tick && fine_ok) begin
                        loss_cnt_next_s = {LW{1'b0}};
                        locked_next_s   = 1'b1;
                    end else if (ref_tick) begin
                        locked_next_s = 1'b0;
                        if (loss_cnt_r >= LOSS_LAST) begin
                            state_next_s = S_BRK_COARSE;
                        end else begin
                            loss_cnt_next_s = loss_cnt_r + 1'b1;
                        end
                    end else begin
                        locked_next_s = locked_r;
                    end
                end
                S_BRK_COARSE: state_next_s = S_COARSE;
                S_BRK_FINE:   state_next_s = S_FINE;
                default:      state_next_s = S_IDLE;
            endcase
        end
        entering_s = (state_next_s != state_r);
        if (entering_s) begin
            tick_cnt_next_s   = {TW{1'b0}};
            settle_cnt_next_s = {SW{1'b0}};
            loss_cnt_next_s   = {LW{1'b0}};
            locked_next_s     = 1'b0;
        end else begin
            locked_next_s = locked_next_s;
        end
    end

    // Output values for the next cycle; mode holds its old value through a break cycle
    always_comb begin
        adc_next_s   = adc_pattern(state_next_s);
        fault_next_s = (state_next_s == S_FAULT);
        case (state_next_s)
            S_IDLE:   mode_next_s = 3'd0;
            S_ZERO:   mode_next_s = 3'd1;
            S_COARSE: mode_next_s = 3'd2;
            S_FINE:   mode_next_s = 3'd3;
            S_FAULT:  mode_next_s = 3'd4;
            default:  mode_next_s = mode_r;
        endcase
        if (entering_s && !abort && (state_next_s != S_BRK_COARSE) && (state_next_s != S_BRK_FINE)) begin
            mode_chg_next_s = 1'b1;
        end else begin
            mode_chg_next_s = 1'b0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            tick_cnt_r   <= {TW{1'b0}};
            settle_cnt_r <= {SW{1'b0}};
            loss_cnt_r   <= {LW{1'b0}};
            locked_r     <= 1'b0;
            adc_r        <= 12'h000;
            mode_r       <= 3'd0;
            fault_r      <= 1'b0;
            mode_chg_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            tick_cnt_r   <= tick_cnt_next_s;
            settle_cnt_r <= settle_cnt_next_s;
            loss_cnt_r   <= loss_cnt_next_s;
            locked_r     <= locked_next_s;
            adc_r        <= adc_next_s;
            mode_r       <= mode_next_s;
            fault_r      <= fault_next_s;
            mode_chg_r   <= mode_chg_next_s;
        end
    end

    assign adc      = adc_r;
    assign mode     = mode_r;
    assign locked   = locked_r;
    assign fault    = fault_r;
    assign mode_chg = mode_chg_r;

endmodule

// File: tb/tb_cdu_mode_sequencer.sv
// Self-checking bench for cdu_mode_sequencer: vector table, directed corner sequences
// and random stimulus compared cycle by cycle against a behavioural model.
module tb_cdu_mode_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, fine1_en = 1'b0;
    logic        ref_tick = 1'b0, coarse_ok = 1'b0, fine_ok = 1'b0;
    logic [11:0] adc;
    logic [2:0]  mode;
    logic        locked, fault, mode_chg;

    int checks = 0;
    int errors = 0;

    cdu_mode_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .fine1_en(fine1_en),
        .ref_tick(ref_tick), .coarse_ok(coarse_ok), .fine_ok(fine_ok),
        .adc(adc), .mode(mode), .locked(locked), .fault(fault), .mode_chg(mode_chg)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode as an integer, an optional pending mode for the zero gap
    int m_mode, m_pend, m_ticks, m_settle, m_loss, m_adc;
    bit m_locked, m_chg;

    function automatic int pat(input int md);
        case (md)
            1: return 12'h002;
            2: return 12'h011;
            3: return 12'h028;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pend = -1; m_ticks = 0; m_settle = 0; m_loss = 0;
        m_adc = 0; m_locked = 0; m_chg = 0;
    endtask

    task automatic model_step();
        int target;
        target = -1;
        m_chg = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (abort) begin
            model_reset();
            return;
        end
        if (m_pend >= 0) begin
            m_mode = m_pend; m_pend = -1; m_adc = pat(m_mode); m_chg = 1;
            m_ticks = 0; m_settle = 0; m_loss = 0; m_locked = 0;
            return;
        end
        if (m_mode == 0 || m_mode == 4) begin
            if (start) target = 1;
        end else if (m_mode == 1) begin
            if (ref_tick) begin
                m_ticks++;
                if (m_ticks >= 8) target = 2;
            end
        end else if (m_mode == 2) begin
            if (ref_tick) begin
                m_settle = coarse_ok ? ((m_settle >= 4) ? 4 : m_settle + 1) : 0;
                if (m_settle == 4 && fine1_en) target = 3;
                else begin
                    m_ticks++;
                    if (m_ticks >= 64) target = 4;
                end
            end
        end else if (m_mode == 3) begin
            if (!fine1_en) target = 2;
            else if (ref_tick) begin
                if (fine_ok) begin
                    m_loss = 0; m_locked = 1;
                end else begin
                    m_locked = 0; m_loss++;
                    if (m_loss >= 2) target = 2;
                end
            end
        end
        if (target >= 0) begin
            m_ticks = 0; m_settle = 0; m_loss = 0; m_locked = 0;
            if (pat(m_mode) != 0 && pat(target) != 0) begin
                m_pend = target; m_adc = 0;
            end else begin
                m_mode = target; m_adc = pat(target); m_chg = 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pack_out();
        return {15'd0, adc, mode, locked, fault, mode_chg};
    endfunction

    function automatic int pack_model();
        return {15'd0, m_adc[11:0], m_mode[2:0], m_locked, (m_mode == 4 && m_pend < 0) ? 1'b1 : 1'b0, m_chg};
    endfunction

    // One clock with the given inputs; outputs compared against the model 1 ns after the edge
    task automatic cyc(input bit r, s, a, fe, t, co, fo);
        rst = r; start = s; abort = a; fine1_en = fe; ref_tick = t; coarse_ok = co; fine_ok = fo;
        @(posedge clk);
        model_step();
        #1;
        chk("model", pack_out(), pack_model());
    endtask

    task automatic idle(input bit fe);
        cyc(1'b0, 1'b0, 1'b0, fe, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick(input bit co, input bit fo);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, co, fo);
    endtask

    task automatic goto_coarse();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) tick(1'b0, 1'b1);
        idle(1'b1);
        chk("coarse_mode", mode, 2);
        chk("coarse_adc", adc, 12'h011);
    endtask

    task automatic goto_fine();
        goto_coarse();
        repeat (4) tick(1'b1, 1'b1);
        idle(1'b1);
        chk("fine_mode", mode, 3);
        chk("fine_adc", adc, 12'h028);
    endtask

    typedef struct {
        bit r, s, a, fe, t, co, fo;
        int e_adc, e_mode;
        bit e_lock, e_fault, e_chg;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit r, s, a, fe, t, co, fo, input int ea, em, input bit el, ef, ec);
        vec_t v;
        v.r = r; v.s = s; v.a = a; v.fe = fe; v.t = t; v.co = co; v.fo = fo;
        v.e_adc = ea; v.e_mode = em; v.e_lock = el; v.e_fault = ef; v.e_chg = ec;
        vt.push_back(v);
    endtask

    initial begin
        int q[$];
        int last_adc, chg_cnt, prev_mode;
        bit lock_checked;
        model_reset();

        // Vector table: reset, start/abort priority, start coinciding with a tick, abort in break
        add(1,0,0,1,0,0,0, 12'h000,0,0,0,0);
        add(0,1,1,1,0,0,0, 12'h000,0,0,0,0);
        add(0,1,0,1,1,0,0, 12'h002,1,0,0,1);
        add(0,0,0,1,0,0,0, 12'h002,1,0,0,0);
        add(0,0,1,1,0,0,0, 12'h000,0,0,0,0);
        add(0,1,0,1,1,0,0, 12'h002,1,0,0,1);
        for (int i = 0; i < 7; i++) add(0,0,0,1,1,0,0, 12'h002,1,0,0,0);
        add(0,0,0,1,1,0,0, 12'h000,1,0,0,0);
        add(0,0,1,1,0,0,0, 12'h000,0,0,0,0);
        add(0,0,0,1,0,0,0, 12'h000,0,0,0,0);
        add(0,1,0,1,0,0,0, 12'h002,1,0,0,1);
        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].r, vt[i].s, vt[i].a, vt[i].fe, vt[i].t, vt[i].co, vt[i].fo);
            chk($sformatf("vec%0d", i),
                {adc, mode, locked, fault, mode_chg},
                {vt[i].e_adc[11:0], vt[i].e_mode[2:0], vt[i].e_lock, vt[i].e_fault, vt[i].e_chg});
        end

        // Nominal acquisition: ticks every 4th cycle, coarse_ok from tick 10
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        last_adc = adc; chg_cnt = 0; lock_checked = 0;
        for (int k = 1; k <= 100; k++) begin
            bit t;
            t = (k % 4 == 0);
            prev_mode = mode;
            cyc(1'b0, 1'b0, 1'b0, 1'b1, t, (k / 4 >= 10), 1'b1);
            if (mode_chg) chg_cnt++;
            if (adc != last_adc) begin
                q.push_back(adc);
                last_adc = adc;
            end
            if (t && prev_mode == 3 && !lock_checked) begin
                chk("nominal_lock", locked, 1);
                lock_checked = 1;
            end
        end
        chk("nominal_chg_count", chg_cnt, 2);
        chk("nominal_seq_len", q.size(), 4);
        if (q.size() == 4) begin
            chk("nominal_seq", {q[0][11:0], q[1][11:0], q[2][11:0], q[3][11:0]},
                {12'h000, 12'h011, 12'h000, 12'h028});
        end

        // Settle restart: 1,1,1,0,1,1,1,1 enters FINE on the 8th tick
        goto_coarse();
        tick(1'b1, 1'b1); tick(1'b1, 1'b1); tick(1'b1, 1'b1); tick(1'b0, 1'b1);
        tick(1'b1, 1'b1); tick(1'b1, 1'b1); tick(1'b1, 1'b1);
        chk("settle_7th_adc", adc, 12'h011);
        tick(1'b1, 1'b1);
        chk("settle_8th_break", adc, 12'h000);
        idle(1'b1);
        chk("settle_fine", {mode, adc}, {3'd3, 12'h028});

        // Fine loss: single 0 drops lock only, two consecutive 0s return to COARSE
        goto_fine();
        tick(1'b1, 1'b1);
        chk("loss_lock1", locked, 1);
        tick(1'b1, 1'b0);
        chk("loss_first0", {locked, mode}, {1'b0, 3'd3});
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        chk("loss_one_zero", {adc, mode}, {12'h028, 3'd3});
        tick(1'b1, 1'b0);
        chk("loss_break", adc, 12'h000);
        idle(1'b1);
        chk("loss_coarse", {adc, mode, mode_chg}, {12'h011, 3'd2, 1'b1});

        // Timeout after 64 ticks with coarse_ok low, then restart from FAULT
        goto_coarse();
        repeat (63) tick(1'b0, 1'b1);
        chk("timeout_63", mode, 2);
        tick(1'b0, 1'b1);
        chk("timeout_fault", {fault, mode, adc}, {1'b1, 3'd4, 12'h000});
        idle(1'b1); idle(1'b1);
        chk("fault_hold", fault, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("fault_restart", {fault, mode}, {1'b0, 3'd1});

        // fine1_en dropped in FINE: zero gap then COARSE
        goto_fine();
        idle(1'b0);
        chk("fen_break", {adc, mode}, {12'h000, 3'd3});
        idle(1'b1);
        chk("fen_coarse", {adc, mode}, {12'h011, 3'd2});

        // Reset mid-FINE coincident with a tick, then a full ZERO count
        goto_fine();
        tick(1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_outputs", {adc, mode, locked, fault, mode_chg}, 20'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (7) tick(1'b0, 1'b1);
        chk("rst_zero7", {adc, mode}, {12'h002, 3'd1});
        tick(1'b0, 1'b1);
        chk("rst_zero8", adc, 12'h000);

        // Random stimulus against the model
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4000; k++) begin
            cyc(($urandom_range(999) == 0), ($urandom_range(7) == 0), ($urandom_range(249) == 0),
                ($urandom_range(39) != 0), ($urandom_range(2) == 0),
                ($urandom_range(9) < 8), ($urandom_range(9) < 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
